shift_right_seq32: RTL
======================

Name: shift_right_seq32

Overview:
- Multi-cycle 32-bit right shifter for the RISC ALU; the right-shift counterpart of the existing combinational left-shift unit.
- Computes C = A >> B, logical (zero fill) or arithmetic (sign fill), one shift-amount bit per cycle, i.e. a serialised log shifter.
- Sits beside the ALU32 datapath and talks to it through valid/ready handshakes on input and output.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, number of shift-amount bits processed (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A, B, arith valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  value to shift.
- B  input  WIDTH  shift amount (full word).
- arith  input  1  1 = arithmetic (SRA), 0 = logical (SRL).
- out_valid  output  1  C holds a result.
- out_ready  input  1  consumer accepts C.
- C  output  WIDTH  shifted result, registered.

Behaviour:
- Clocking and reset: single clock domain; asynchronous active-low reset.
  - During rst_n=0: state=IDLE, in_ready=1, out_valid=0, C=0, internal acc/shamt/cnt=0.
  - Reset mid-operation discards the operation; nothing is emitted.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch acc=A, shamt=B[4:0], fill = arith ? A[31] : 0.
  - Overflow = |B[31:5]. If overflow, go to DONE with acc = {32{fill}}; otherwise go to SHIFT with cnt=0.
- SHIFT:
  - in_ready=0.
  - Each cycle: if shamt[cnt], acc = acc >> 2^cnt, vacated MSBs = fill. Then cnt increments.
  - After the cnt=4 step, go to DONE.
  - Shift amount 0 still spends 5 cycles in SHIFT.
- DONE:
  - out_valid=1; C = acc, held stable while out_ready=0; in_ready=0.
  - On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - 1 cycle for overflow.
  - 6 cycles otherwise (5 SHIFT cycles, then DONE).
- No overlap: a new operation cannot be accepted in the same cycle a result is consumed. in_valid outside IDLE is ignored; the source must hold it.
- A, B and arith are sampled only at the accept edge; later changes have no effect.
- fill is taken from the latched A[31], not from the live input.

Optional Feature:
- Macro SHR_EARLY_EXIT_EN.
- When defined:
  - shamt==0 (no overflow) goes from IDLE straight to DONE with acc=A; latency 1.
  - In SHIFT, after processing bit cnt, if shamt[4:cnt+1]==0, go to DONE.
  - Latency = msb_index(shamt)+2.
- When undefined: fixed latency as in Behaviour. Results are bit-identical in both builds.

Decomposition:
- Package shift_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - WIDTH and SHAMT_W constants.
  - localparam LAST_STAGE = SHAMT_W-1.
- Sub-module shr_stage (combinational):
  - Inputs: data, stage index k, enable, fill.
  - Output: data >> 2^k with fill, or data unchanged when enable=0.
  - Instantiated once and driven by cnt.

Test Plan:
- A=0x80000000, B=4, arith=0 -> C=0x08000000; out_valid rises 6 cycles after accept (fixed build), 4 cycles with SHR_EARLY_EXIT_EN.
- Same A and B, arith=1 -> C=0xF8000000.
- B=0x00000020 (overflow), A=0x80000001 -> arith=1: C=0xFFFFFFFF; arith=0: C=0x00000000; out_valid 1 cycle after accept.
- A=0xFFFFFFFF, B=31, arith=0 -> C=0x00000001. B=0, A=0x12345678 -> C=0x12345678.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> C stable, out_valid=1, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next cycle, then the new op is accepted.
- Assert rst_n=0 during the 2nd SHIFT cycle -> immediately out_valid=0, C=0, in_ready=1. After release, the next op completes with the correct result.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and FSM state type for the sequential right shifter.
package shift_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned LAST_STAGE = SHAMT_W - 1;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shr_stage.sv
// One log-shifter stage: shifts right by 2^k with the given fill bit when enabled.
module shr_stage
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] k,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted_c
);

    logic [2*WIDTH-1:0] ext;

    // Fill word sits above the data so a plain shift brings in fill bits.
    always_comb begin
        ext       = {{WIDTH{fill}}, data} >> (WIDTH'(1) << k);
        shifted_c = en ? ext[WIDTH-1:0] : data;
    end

endmodule

// File: rtl/shift_right_seq32.sv
// Serialised 32-bit logical/arithmetic right shifter with valid/ready handshakes.
// Optional macro SHR_EARLY_EXIT_EN ends the shift as soon as no higher shamt bits remain.
module shift_right_seq32
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic               in_ready_d, out_valid_d;
    logic [WIDTH-1:0]   c_d;
    logic [SHAMT_W-1:0] shamt_rem_c;
    logic [WIDTH-1:0]   stage_out_c;

    // Bit 0 of the remaining amount is the current stage's enable.
    assign shamt_rem_c = shamt_q >> cnt_q;

    shr_stage u_stage (
        .data      (acc_q),
        .k         (cnt_q),
        .en        (shamt_rem_c[0]),
        .fill      (fill_q),
        .shifted_c (stage_out_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            shamt_q   <= '0;
            cnt_q     <= '0;
            fill_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            C         <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            shamt_q   <= shamt_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            C         <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        shamt_d = shamt_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    fill_d  = arith & A[WIDTH-1];
                    acc_d   = A;
                    shamt_d = B[SHAMT_W-1:0];
                    cnt_d   = '0;
                    // Any amount >= WIDTH shifts everything out.
                    if (|B[WIDTH-1:SHAMT_W]) begin
                        acc_d   = {WIDTH{fill_d}};
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
`ifdef SHR_EARLY_EXIT_EN
                        if (B[SHAMT_W-1:0] == '0) begin
                            state_d = DONE;
                        end
`endif
                    end
                end
            end
            SHIFT: begin
                acc_d = stage_out_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LAST_STAGE)) begin
                    state_d = DONE;
                end
`ifdef SHR_EARLY_EXIT_EN
                if (shamt_rem_c[SHAMT_W-1:1] == '0) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        c_d         = ((state_d == DONE) && (state_q != DONE)) ? acc_d : C;
    end

endmodule
